// File: rtl/serial_rf_pkg.sv
// Shared types and sizing helpers for the bit-serial register file.
package serial_rf_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rf_state_t;

  // Bits needed to count 0..width-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_reg_file_if.sv
// Transfer handshake and serial operand/result bit streams of the register file.
interface serial_reg_file_if #(
  parameter int unsigned ADDR_W = 3
);
  logic              start;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_we;
  logic              rd_bit;
  logic              rs1_bit;
  logic              rs2_bit;
  logic              bit_valid;
  logic              last;
  logic              busy;
  logic              done;

  modport master (
    output start, rs1_addr, rs2_addr, rd_addr, rd_we, rd_bit,
    input  rs1_bit, rs2_bit, bit_valid, last, busy, done
  );

  modport slave (
    input  start, rs1_addr, rs2_addr, rd_addr, rd_we, rd_bit,
    output rs1_bit, rs2_bit, bit_valid, last, busy, done
  );
endinterface

// File: rtl/serial_reg_file_bit_counter.sv
// Bit index counter for one serial transfer; wraps to 0 after the terminal count.
module bit_counter
  import serial_rf_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] k,
  output logic             tc_c
);

  assign tc_c = (k == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= '0;
    end else if (clear) begin
      k <= '0;
    end else if (enable) begin
      k <= tc_c ? '0 : k + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_reg_file.sv
// Bit-serial register file: streams two operands out LSB-first while one result
// streams in, with an optional hardwired zero register and a parallel debug read.
module serial_reg_file
  import serial_rf_pkg::*;
#(
  parameter  int unsigned WIDTH    = 16,
  parameter  int unsigned NREGS    = 8,
  parameter  bit          ZERO_REG = 1'b1,
  localparam int unsigned ADDR_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_reg_file_if.slave  bus,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
);

  localparam int unsigned CNT_W    = cnt_width(WIDTH);
  localparam logic [0:0]  ST_IDLE  = IDLE;
  localparam logic [0:0]  ST_SHIFT = SHIFT;

  logic [0:0]        state_q, state_d;
  logic              accept;
  logic [ADDR_W-1:0] rs1_l, rs2_l, rd_l;
  logic              rd_we_l;
  logic              done_q;
  logic [CNT_W-1:0]  k;
  logic              tc;
  logic              shifting;
  logic              wr_en;
  logic [WIDTH-1:0]  regs [NREGS];
  logic [WIDTH-1:0]  rs1_word, rs2_word;

  assign shifting = (state_q == ST_SHIFT);

  // A start is taken in IDLE, or on the last bit to chain transfers without a bubble.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tc) begin
          if (bus.start) accept  = 1'b1;
          else           state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rs1_l   <= '0;
      rs2_l   <= '0;
      rd_l    <= '0;
      rd_we_l <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= shifting & tc;
      if (accept) begin
        rs1_l   <= bus.rs1_addr;
        rs2_l   <= bus.rs2_addr;
        rd_l    <= bus.rd_addr;
        rd_we_l <= bus.rd_we;
      end
    end
  end

  bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .enable (shifting),
    .k      (k),
    .tc_c   (tc)
  );

  // Bit k is overwritten at the end of cycle k, so same-cycle reads see the old bit.
  assign wr_en = shifting && rd_we_l && !(ZERO_REG && rd_l == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[rd_l][k] <= bus.rd_bit;
    end
  end

  always_comb begin
    rs1_word = regs[rs1_l];
    rs2_word = regs[rs2_l];
    dbg_data = regs[dbg_addr];
    if (ZERO_REG && rs1_l == '0)    rs1_word = '0;
    if (ZERO_REG && rs2_l == '0)    rs2_word = '0;
    if (ZERO_REG && dbg_addr == '0) dbg_data = '0;
  end

  assign bus.rs1_bit   = shifting & rs1_word[k];
  assign bus.rs2_bit   = shifting & rs2_word[k];
  assign bus.bit_valid = shifting;
  assign bus.busy      = shifting;
  assign bus.last      = shifting & tc;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_serial_reg_file.sv
// Directed bench for serial_reg_file with an operand-stream scoreboard and register model.
module tb_serial_reg_file;

  logic        clk;
  logic        rst_n;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  serial_reg_file_if #(.ADDR_W(3)) bus ();

  serial_reg_file #(.WIDTH(16), .NREGS(8), .ZERO_REG(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] mdl [8];
  logic [1:0]  sb_q [$];
  logic [2:0]  pend_rd;
  logic        pend_we;
  logic [15:0] pend_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mdl_rd(input logic [2:0] a);
    return (a == 3'd0) ? 16'h0000 : mdl[a];
  endfunction

  // Drive a start and push the operand bits this transfer must stream.
  task automatic issue(input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                       input logic we, input logic [15:0] data);
    logic [15:0] w1, w2;
    w1 = mdl_rd(rs1);
    w2 = mdl_rd(rs2);
    bus.start    = 1'b1;
    bus.rs1_addr = rs1;
    bus.rs2_addr = rs2;
    bus.rd_addr  = rd;
    bus.rd_we    = we;
    for (int i = 0; i < 16; i++) sb_q.push_back({w2[i], w1[i]});
    pend_rd   = rd;
    pend_we   = we;
    pend_data = data;
  endtask

  task automatic commit();
    if (pend_we && pend_rd != 3'd0) mdl[pend_rd] = pend_data;
  endtask

  task automatic shift_phase(input bit done_first, input int ign_k, input bit chain,
                             input logic [2:0] n_rs1, input logic [2:0] n_rs2,
                             input logic [2:0] n_rd, input logic n_we, input logic [15:0] n_data);
    logic [15:0] data;
    logic [1:0]  exp;
    data = pend_data;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 2'bxx;
      chk("bit_valid", 32'(bus.bit_valid), 32'd1);
      chk("busy", 32'(bus.busy), 32'd1);
      chk("last", 32'(bus.last), 32'(k == 15));
      chk("done_in_shift", 32'(bus.done), 32'(k == 0 && done_first));
      chk("rs1_bit", 32'(bus.rs1_bit), 32'(exp[0]));
      chk("rs2_bit", 32'(bus.rs2_bit), 32'(exp[1]));
      bus.rd_bit = data[k];
      if (k == ign_k) begin
        bus.start    = 1'b1;
        bus.rs1_addr = 3'd7;
        bus.rs2_addr = 3'd7;
        bus.rd_addr  = 3'd2;
        bus.rd_we    = 1'b1;
      end
      if (k == 15 && chain) begin
        commit();
        issue(n_rs1, n_rs2, n_rd, n_we, n_data);
      end
    end
    if (!chain) begin
      commit();
      @(negedge clk);
      bus.start = 1'b0;
      chk("done_pulse", 32'(bus.done), 32'd1);
      chk("busy_after", 32'(bus.busy), 32'd0);
      chk("bit_valid_after", 32'(bus.bit_valid), 32'd0);
      chk("rs1_bit_idle", 32'(bus.rs1_bit), 32'd0);
    end
  endtask

  task automatic dbg_chk(input logic [2:0] a);
    dbg_addr = a;
    #1;
    chk($sformatf("dbg_data[%0d]", a), 32'(dbg_data), 32'(mdl_rd(a)));
  endtask

  task automatic run(input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                     input logic we, input logic [15:0] data, input int ign_k);
    @(negedge clk);
    issue(rs1, rs2, rd, we, data);
    shift_phase(1'b0, ign_k, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0);
  endtask

  initial begin
    bit done_seen;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;
    bus.rd_addr  = '0;
    bus.rd_we    = 1'b0;
    bus.rd_bit   = 1'b0;
    dbg_addr     = '0;
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_last", 32'(bus.last), 32'd0);
    chk("rst_bit_valid", 32'(bus.bit_valid), 32'd0);
    chk("rst_rs1_bit", 32'(bus.rs1_bit), 32'd0);
    for (int i = 0; i < 8; i++) dbg_chk(3'(i));

    // Single write: r3 = 0xA5C3, done 17 cycles after start
    run(3'd0, 3'd0, 3'd3, 1'b1, 16'hA5C3, -1);
    dbg_chk(3'd3);

    // Operand stream of r1 = 0x1234 and r2 = 0xFFFF, no write-back
    run(3'd0, 3'd0, 3'd1, 1'b1, 16'h1234, -1);
    run(3'd0, 3'd0, 3'd2, 1'b1, 16'hFFFF, -1);
    run(3'd1, 3'd2, 3'd1, 1'b0, 16'hDEAD, -1);
    dbg_chk(3'd1);
    dbg_chk(3'd2);

    // Read-before-write on r4
    run(3'd0, 3'd0, 3'd4, 1'b1, 16'h00FF, -1);
    run(3'd4, 3'd3, 3'd4, 1'b1, 16'hFF00, -1);
    dbg_chk(3'd4);

    // Zero register ignores writes and streams zeros
    run(3'd3, 3'd1, 3'd0, 1'b1, 16'hBEEF, -1);
    dbg_chk(3'd0);
    run(3'd0, 3'd0, 3'd5, 1'b0, 16'h0000, -1);

    // Start at k=5 is ignored
    run(3'd1, 3'd4, 3'd6, 1'b1, 16'h5A5A, 5);
    dbg_chk(3'd6);
    dbg_chk(3'd2);

    // Back-to-back: second transfer reads r7 written by the first
    @(negedge clk);
    issue(3'd6, 3'd3, 3'd7, 1'b1, 16'h0F0F);
    shift_phase(1'b0, -1, 1'b1, 3'd7, 3'd6, 3'd5, 1'b1, 16'h8001);
    shift_phase(1'b1, -1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0);
    dbg_chk(3'd7);
    dbg_chk(3'd5);

    // Reset mid-transfer discards everything and suppresses done
    @(negedge clk);
    issue(3'd1, 3'd2, 3'd5, 1'b1, 16'h1357);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.start  = 1'b0;
      bus.rd_bit = 1'b1;
    end
    rst_n = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_bit_valid", 32'(bus.bit_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) dbg_chk(3'(i));
    done_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen = 1'b1;
    end
    chk("abort_no_done", 32'(done_seen), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_reg_file.md
# serial_reg_file

Parametrised bit-serial register file for the 16-bit serial CPU datapath. It replaces the parallel single-port-write register file. Per transfer it streams two source operands out LSB-first, one bit per cycle, and streams one result in at the same bit rate. Register count, data width and a hardwired zero register are configurable. A parallel debug read port supports load/inspection.

## Interface
- `WIDTH`, 16, data bits per register and cycles per transfer (≥2)
- `NREGS`, 8, number of registers (power of two, ≥2)
- `ZERO_REG`, 1, when 1 register 0 reads as 0 and ignores writes
- `ADDR_W`, `$clog2(NREGS)`, derived, not overridable

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request a transfer, sampled on `clk`
- `rs1_addr`, `rs2_addr`, `rd_addr`  in  ADDR_W each  operand/destination indices, sampled with `start`
- `rd_we`  in  1  write-back enable for the transfer, sampled with `start`
- `rd_bit`  in  1  serial result bit k, sampled during SHIFT
- `rs1_bit`, `rs2_bit`  out  1  serial operand bit k
- `bit_valid`  out  1  high during each SHIFT cycle
- `last`  out  1  high on SHIFT cycle k = WIDTH-1
- `busy`  out  1  high in SHIFT
- `done`  out  1  one-cycle pulse the cycle after `last`
- `dbg_addr`  in  ADDR_W  debug read index
- `dbg_data`  out  WIDTH  combinational `reg[dbg_addr]`

## Operation
- States: IDLE, SHIFT.
- **IDLE**
  - `start`=1 latches `rs1_addr`, `rs2_addr`, `rd_addr`, `rd_we`, clears k to 0, and moves to SHIFT.
- **SHIFT**
  - `rs1_bit = reg[rs1_l][k]`, `rs2_bit = reg[rs2_l][k]`.
  - On the clock edge ending the cycle, when `rd_we_l` is set, `reg[rd_l][k] <= rd_bit`.
  - k increments by 1 each cycle.
- **Last bit (k = WIDTH-1)**
  - `last`=1.
  - With `start`=1 that cycle: latch new addresses, k wraps to 0, stay in SHIFT (back-to-back, no bubble).
  - Otherwise go to IDLE.
- **`start` while in SHIFT, k < WIDTH-1:** ignored, no queuing.
- **Read-before-write:** when rd equals rs1 or rs2, the operand stream returns the old bit k. Bit k is overwritten only at the end of cycle k, so reads are never disturbed.
- **Zero register (`ZERO_REG`=1):** writes to index 0 are dropped; reads of index 0 return 0 on both serial and debug ports.
- `rs1_bit`/`rs2_bit` are forced to 0 when `bit_valid`=0.
- **Reset (async, any state, including mid-SHIFT):**
  - all registers ← 0, state ← IDLE, k ← 0
  - `busy`, `bit_valid`, `last`, `done`, `rs1_bit`, `rs2_bit` ← 0
  - a partial write is discarded (all registers are cleared).

## Timing
- **Cycle 0:** `start` sampled in IDLE.
- **Cycles 1..WIDTH:** SHIFT bits 0..WIDTH-1.
- **Cycle WIDTH+1:** `done`=1.
  - Back-to-back: `done` coincides with bit 0 of the next transfer.
- **Latency:** operand bit k is valid in cycle k+1; registered state, combinational read mux.
- **Commit:** a written register is fully committed at `done`.
  - `dbg_data` shows each bit as soon as that bit's edge passes.
  - A transfer starting back-to-back reads fully updated values.
- **Throughput:** one transfer per WIDTH cycles sustained.

## Structure
- Package `serial_rf_pkg`:
  - `rf_state_t` enum {IDLE, SHIFT}
  - `localparam` helper for counter width `$clog2(WIDTH)`
- Sub-module `bit_counter`:
  - parametrised by WIDTH
  - inputs: clear, enable
  - outputs: k, terminal-count flag feeding `last`
- Register array, read muxes and write decode stay in `serial_reg_file`.

## Test plan
- **Reset then readback:** pulse `rst_n` low mid-SHIFT → all `dbg_data` = 0x0000, `busy`=0, `done` never fires for the aborted transfer.
- **Single write:** start rd=3, we=1, stream 0xA5C3 LSB-first → `done` exactly 17 cycles after `start`; `dbg_data[3]`=0xA5C3.
- **Operand stream:** preload r1=0x1234, r2=0xFFFF; start rs1=1, rs2=2, we=0 → `rs1_bit` sequence 0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0; `rs2_bit` all 1; registers unchanged.
- **Read-before-write:** r4=0x00FF; start rs1=4, rd=4, we=1, `rd_bit` = bits of 0xFF00 → `rs1_bit` streams 0x00FF; afterwards r4=0xFF00.
- **Zero register:** start rd=0, we=1, stream 0xBEEF → `dbg_data[0]`=0; rs1=0 streams all zeros.
- **Back-to-back/ignored start:**
  - `start` asserted at k=5 → ignored.
  - `start` on the `last` cycle → next SHIFT begins with no IDLE cycle; `done` and `bit_valid` both high that cycle.
